load_extend_unit: RTL and testbench
===================================

Name: load_extend_unit

Overview:
Two-stage pipelined load-data aligner and extender for the memory-read return path. It takes a raw XLEN-bit memory word with byte offset, access size and signedness, and selects the addressed byte, half, word or double. It then sign- or zero-extends the selection to XLEN and flags misaligned or illegal accesses. Valid/ready handshakes on both sides give full-throughput streaming with backpressure; it sits between the data-memory interface and register-file writeback.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 5, width of the opaque tag carried alongside each load (rd index).
OFF_W, $clog2(XLEN/8), byte-offset width; derived, not to be overridden.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
flush  in  1  synchronous pipeline kill.
in_valid  in  1  input transfer valid.
in_ready  out  1  unit can accept input.
in_data  in  XLEN  raw memory word.
in_offset  in  OFF_W  byte offset of access within word.
in_size  in  2  mem_size_e: B=0, H=1, W=2, D=3.
in_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
in_tag  in  TAG_W  passthrough tag.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
out_data  out  XLEN  extended result.
out_tag  out  TAG_W  tag of result.
out_misaligned  out  1  access misaligned/illegal; out_data forced 0.

Behaviour:
- Reset (async, rst=1): s1_valid, s2_valid, all payload registers <= 0. Outputs out_valid=0, out_data=0, out_tag=0, out_misaligned=0. in_ready=1 once valids are clear.
- Handshake: a transfer occurs when valid && ready on the same rising edge. in_valid and payload must be held until accepted. out_data, out_tag and out_misaligned are stable while out_valid && !out_ready.
- Stall logic (combinational):
  - s2_en = !s2_valid || out_ready
  - s1_en = !s1_valid || s2_en
  - in_ready = s1_en
- Stage 1 (on s1_en): s1_valid <= in_valid. Capture in_data >> (8*in_offset), size, unsigned and tag.
- Stage 1 misalignment: misaligned = (in_offset & (bytes(size)-1)) != 0. Also misaligned when size==D and XLEN==32.
- Stage 2 (on s2_en): s2_valid <= s1_valid. Extend the low 8/16/32/64 bits of the shifted word to XLEN:
  - sign bit replicated when unsigned=0, zeros when unsigned=1.
  - size==W with XLEN==32 passes through unchanged.
  - misaligned: data 0, flag 1.
- Outputs are driven directly from stage-2 registers; no combinational path from in_* to out_*.
- Latency 2 cycles from accepted input to out_valid with out_ready=1. Throughput 1 per cycle. Maximum 2 in flight.
- Ordering: strict FIFO order. Under any out_ready pattern, no result is dropped or duplicated.
- flush=1: s1_valid and s2_valid <= 0 at the next edge, overriding all enables. An input accepted in the flush cycle is discarded. Payload registers may retain stale values.
- Async reset mid-transfer: out_valid drops immediately without waiting for a clock edge; in-flight loads are lost.
- Offset bits above the access size are don't-care only when they do not cause misalignment; misalignment detection uses all OFF_W bits.

Decomposition:
- In the shared types_pkg:
  - typedef enum logic [1:0] mem_size_e {SZ_B, SZ_H, SZ_W, SZ_D}
  - function size_bytes(mem_size_e)
- Natural sub-module: ext_pipe_reg, a single valid/ready register slice parametrised by payload width with flush and async reset. It is instantiated twice, with the align and extend logic between the slices.

Test Plan:
1. XLEN=32, in_data=0x8070F0A5, offset 0, size B:
   - signed -> out_data 0xFFFFFFA5 two cycles after accept.
   - unsigned -> 0x000000A5.
2. Same word, offset 2, size H:
   - signed -> 0xFFFF8070.
   - unsigned -> 0x00008070.
   - offset 3, size B, signed -> 0xFFFFFF80.
3. Offset 1 size H, offset 2 size W, and size D on XLEN=32 -> out_misaligned=1, out_data=0, tag preserved.
4. Four back-to-back loads (tags 1–4) with out_ready=0 for 3 cycles:
   - in_ready drops after 2 accepts.
   - out_data stable during the stall.
   - results emerge in order 1,2,3,4 with none lost.
5. Both stages full, flush pulsed one cycle:
   - out_valid=0 next cycle.
   - a new load accepted after the flush cycle appears exactly 2 cycles later.
6. XLEN=64, in_data=0x80000000_12345678:
   - offset 4 size W signed -> 0xFFFFFFFF80000000.
   - offset 0 size D -> unchanged.
   - async rst asserted mid-stream -> out_valid=0 before the next edge.

Source files
------------

// File: rtl/types_pkg.sv
// Shared load-path types: access size encoding and its byte count.
package types_pkg;

   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} mem_size_e;

   function automatic logic [3:0] size_bytes(input mem_size_e size);
      case (size)
         SZ_B:    return 4'd1;
         SZ_H:    return 4'd2;
         SZ_W:    return 4'd4;
         default: return 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/ext_pipe_reg.sv
// Single valid/ready register slice; holds its payload while the consumer stalls.
module ext_pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   assign in_ready = !out_valid || out_ready;

   // Flush only kills the valid bit; the payload is allowed to go stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         out_data  <= in_data;
      end
   end

endmodule

// File: rtl/load_extend_unit.sv
// Two-stage load aligner/extender: stage 1 shifts and checks alignment,
// stage 2 registers the sign/zero-extended result.
module load_extend_unit
   import types_pkg::*;
#(
   parameter  int XLEN  = 32,
   parameter  int TAG_W = 5,
   localparam int OFF_W = $clog2(XLEN/8)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_data,
   input  logic [OFF_W-1:0] in_offset,
   input  logic [1:0]       in_size,
   input  logic             in_unsigned,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_misaligned
);

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             mis;
      logic             uns;
      mem_size_e        size;
      logic [XLEN-1:0]  word;
   } s1_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic             mis;
      logic [XLEN-1:0]  data;
   } s2_t;

   s1_t              s1_in, s1_q;
   s2_t              s2_in, s2_q;
   logic             s1_valid, s2_valid, s2_en;
   mem_size_e        size_in;
   logic [OFF_W-1:0] off_mask;

   assign size_in  = mem_size_e'(in_size);
   assign off_mask = OFF_W'(size_bytes(size_in) - 4'd1);

   // Any set offset bit below the access size is misaligned; doubles do not exist on RV32.
   always_comb begin
      s1_in      = '0;
      s1_in.tag  = in_tag;
      s1_in.uns  = in_unsigned;
      s1_in.size = size_in;
      s1_in.word = in_data >> {in_offset, 3'b000};
      s1_in.mis  = ((in_offset & off_mask) != '0) || (size_in == SZ_D && XLEN < 64);
   end

   ext_pipe_reg #(.W($bits(s1_t))) u_s1 (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (s1_in),
      .out_valid (s1_valid),
      .out_ready (s2_en),
      .out_data  (s1_q)
   );

   // Bits below the access width pass through; the rest take the fill bit.
   always_comb begin
      int   bits;
      logic sign;
      logic fill;
      logic [XLEN-1:0] ext;
      bits = XLEN;
      sign = 1'b0;
      ext  = '0;
      case (s1_q.size)
         SZ_B:    begin bits = 8;    sign = s1_q.word[7];      end
         SZ_H:    begin bits = 16;   sign = s1_q.word[15];     end
         SZ_W:    begin bits = 32;   sign = s1_q.word[31];     end
         default: begin bits = XLEN; sign = s1_q.word[XLEN-1]; end
      endcase
      fill = sign && !s1_q.uns;
      for (int i = 0; i < XLEN; i++) begin
         ext[i] = (i < bits) ? s1_q.word[i] : fill;
      end
      s2_in      = '0;
      s2_in.tag  = s1_q.tag;
      s2_in.mis  = s1_q.mis;
      s2_in.data = s1_q.mis ? '0 : ext;
   end

   ext_pipe_reg #(.W($bits(s2_t))) u_s2 (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (s1_valid),
      .in_ready  (s2_en),
      .in_data   (s2_in),
      .out_valid (s2_valid),
      .out_ready (out_ready),
      .out_data  (s2_q)
   );

   assign out_valid      = s2_valid;
   assign out_data       = s2_q.data;
   assign out_tag        = s2_q.tag;
   assign out_misaligned = s2_q.mis;

endmodule

// File: tb/tb_load_extend_unit.sv
// Self-checking bench for load_extend_unit at XLEN=32 and XLEN=64.
module tb_load_extend_unit;

   logic clk = 1'b0;
   logic rst, flush;
   always #5 clk = ~clk;

   logic        a_in_valid, a_in_ready, a_in_unsigned, a_out_valid, a_out_ready, a_out_mis;
   logic [31:0] a_in_data, a_out_data;
   logic [1:0]  a_in_offset, a_in_size;
   logic [4:0]  a_in_tag, a_out_tag;

   logic        b_in_valid, b_in_ready, b_in_unsigned, b_out_valid, b_out_ready, b_out_mis;
   logic [63:0] b_in_data, b_out_data;
   logic [2:0]  b_in_offset;
   logic [1:0]  b_in_size;
   logic [4:0]  b_in_tag, b_out_tag;

   int checks = 0;
   int errors = 0;

   load_extend_unit #(.XLEN(32), .TAG_W(5)) dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_offset(a_in_offset), .in_size(a_in_size), .in_unsigned(a_in_unsigned),
      .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_data(a_out_data), .out_tag(a_out_tag), .out_misaligned(a_out_mis)
   );

   load_extend_unit #(.XLEN(64), .TAG_W(5)) dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_offset(b_in_offset), .in_size(b_in_size), .in_unsigned(b_in_unsigned),
      .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_tag(b_out_tag), .out_misaligned(b_out_mis)
   );

   // Reference: mask the shifted word to the access width, then OR in the sign.
   function automatic logic [64:0] ref_load(input int xlen, input logic [63:0] data,
                                            input int off, input int size, input bit uns);
      int nb;
      logic [63:0] sh, mask, res;
      bit mis;
      nb   = 1 << size;
      mis  = ((off % nb) != 0) || (8 * nb > xlen);
      sh   = data >> (8 * off);
      mask = (nb == 8) ? {64{1'b1}} : ((64'd1 << (8 * nb)) - 64'd1);
      res  = sh & mask;
      if (!uns && sh[8*nb-1]) res = res | ~mask;
      if (xlen == 32) res = res & 64'h0000_0000_FFFF_FFFF;
      if (mis) res = '0;
      return {mis, res};
   endfunction

   task automatic drive_a(input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz,
                          input logic u, input logic [4:0] t);
      a_in_valid = 1'b1; a_in_data = d; a_in_offset = off;
      a_in_size = sz; a_in_unsigned = u; a_in_tag = t;
   endtask

   task automatic drive_b(input logic [63:0] d, input logic [2:0] off, input logic [1:0] sz,
                          input logic u, input logic [4:0] t);
      b_in_valid = 1'b1; b_in_data = d; b_in_offset = off;
      b_in_size = sz; b_in_unsigned = u; b_in_tag = t;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0;
      a_in_valid = 0; a_in_data = 0; a_in_offset = 0; a_in_size = 0; a_in_unsigned = 0; a_in_tag = 0;
      b_in_valid = 0; b_in_data = 0; b_in_offset = 0; b_in_size = 0; b_in_unsigned = 0; b_in_tag = 0;
      a_out_ready = 1'b1; b_out_ready = 1'b1;
      #12;
      checks++;
      if ({a_out_valid, a_out_data, a_out_tag, a_out_mis, a_in_ready} !== {1'b0, 32'd0, 5'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL reset32 got v=%b d=%h t=%h m=%b rdy=%b want 0 0 0 0 1",
                  a_out_valid, a_out_data, a_out_tag, a_out_mis, a_in_ready);
      end
      checks++;
      if ({b_out_valid, b_out_data, b_out_tag, b_out_mis, b_in_ready} !== {1'b0, 64'd0, 5'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL reset64 got v=%b d=%h t=%h m=%b rdy=%b want 0 0 0 0 1",
                  b_out_valid, b_out_data, b_out_tag, b_out_mis, b_in_ready);
      end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   typedef struct {
      logic [2:0]  off;
      logic [1:0]  size;
      logic        uns;
      logic [63:0] exp;
      logic        mis;
   } vec_t;

   task automatic test_directed32();
      vec_t v[12];
      v[0]  = '{3'd0, 2'd0, 1'b0, 64'hFFFFFFA5, 1'b0};
      v[1]  = '{3'd0, 2'd0, 1'b1, 64'h000000A5, 1'b0};
      v[2]  = '{3'd2, 2'd1, 1'b0, 64'hFFFF8070, 1'b0};
      v[3]  = '{3'd2, 2'd1, 1'b1, 64'h00008070, 1'b0};
      v[4]  = '{3'd3, 2'd0, 1'b0, 64'hFFFFFF80, 1'b0};
      v[5]  = '{3'd1, 2'd1, 1'b0, 64'h0,        1'b1};
      v[6]  = '{3'd2, 2'd2, 1'b0, 64'h0,        1'b1};
      v[7]  = '{3'd0, 2'd3, 1'b0, 64'h0,        1'b1};
      v[8]  = '{3'd1, 2'd0, 1'b1, 64'h000000F0, 1'b0};
      v[9]  = '{3'd1, 2'd0, 1'b0, 64'hFFFFFFF0, 1'b0};
      v[10] = '{3'd0, 2'd2, 1'b0, 64'h8070F0A5, 1'b0};
      v[11] = '{3'd0, 2'd1, 1'b0, 64'hFFFFF0A5, 1'b0};
      a_out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1 drive_a(32'h8070F0A5, v[i].off[1:0], v[i].size, v[i].uns, 5'(i + 3));
         @(posedge clk); #1 a_in_valid = 1'b0;
         #1;
         checks++;
         if (a_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dir32_early[%0d] out_valid got %b want 0", i, a_out_valid);
         end
         @(posedge clk); #2;
         checks++;
         if ({a_out_valid, a_out_data, a_out_mis, a_out_tag} !== {1'b1, v[i].exp[31:0], v[i].mis, 5'(i + 3)}) begin
            errors++;
            $display("[TB] FAIL dir32[%0d] got v=%b d=%h m=%b t=%0d want v=1 d=%h m=%b t=%0d",
                     i, a_out_valid, a_out_data, a_out_mis, a_out_tag, v[i].exp[31:0], v[i].mis, i + 3);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d[4];
      logic [1:0]  sz[4], off[4];
      logic        u[4];
      logic [64:0] e[4];
      int sent = 0, rx = 0;
      bit fire_in, fire_out;
      for (int i = 0; i < 4; i++) begin
         d[i]   = $urandom;
         sz[i]  = 2'($urandom_range(0, 2));
         off[i] = 2'($urandom_range(0, 3)) & ~2'((1 << sz[i]) - 1);
         u[i]   = 1'($urandom_range(0, 1));
         e[i]   = ref_load(32, {32'd0, d[i]}, int'(off[i]), int'(sz[i]), u[i]);
      end
      @(posedge clk);
      for (int c = 0; c < 30 && rx < 4; c++) begin
         #1 a_out_ready = (c >= 5);
         if (sent < 4) drive_a(d[sent], off[sent], sz[sent], u[sent], 5'(sent + 1));
         else a_in_valid = 1'b0;
         #1;
         if (c == 2) begin
            checks++;
            if (sent != 2 || a_in_ready !== 1'b0) begin
               errors++;
               $display("[TB] FAIL b2b_ready accepts=%0d in_ready=%b want 2 and 0", sent, a_in_ready);
            end
         end
         if (c >= 2 && c <= 4) begin
            checks++;
            if ({a_out_valid, a_out_data, a_out_tag} !== {1'b1, e[0][31:0], 5'd1}) begin
               errors++;
               $display("[TB] FAIL b2b_stall[%0d] got v=%b d=%h t=%0d want v=1 d=%h t=1",
                        c, a_out_valid, a_out_data, a_out_tag, e[0][31:0]);
            end
         end
         fire_in  = a_in_valid && a_in_ready;
         fire_out = a_out_valid && a_out_ready;
         if (fire_out) begin
            checks++;
            if ({a_out_data, a_out_mis, a_out_tag} !== {e[rx][31:0], e[rx][64], 5'(rx + 1)}) begin
               errors++;
               $display("[TB] FAIL b2b_out[%0d] got d=%h m=%b t=%0d want d=%h m=%b t=%0d",
                        rx, a_out_data, a_out_mis, a_out_tag, e[rx][31:0], e[rx][64], rx + 1);
            end
            rx++;
         end
         @(posedge clk);
         if (fire_in) sent++;
      end
      #1 a_in_valid = 1'b0;
      checks++;
      if (rx != 4 || sent != 4) begin
         errors++;
         $display("[TB] FAIL b2b_count got sent=%0d recv=%0d want 4 4", sent, rx);
      end
   endtask

   task automatic test_flush();
      logic [64:0] e;
      e = ref_load(32, 64'h0000_0000_C3B2_17E4, 2, 1, 0);
      @(posedge clk); #1 a_out_ready = 1'b0; drive_a(32'h11111111, 2'd0, 2'd2, 1'b0, 5'd20);
      @(posedge clk); #1 drive_a(32'h22222222, 2'd0, 2'd2, 1'b0, 5'd21);
      @(posedge clk); #1 a_in_valid = 1'b0; flush = 1'b1;
      #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_full got v=%b rdy=%b want 1 0", a_out_valid, a_in_ready);
      end
      @(posedge clk); #1 flush = 1'b0; a_out_ready = 1'b1;
      drive_a(32'hC3B217E4, 2'd2, 2'd1, 1'b0, 5'd22);
      #1;
      checks++;
      if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_clear got v=%b rdy=%b want 0 1", a_out_valid, a_in_ready);
      end
      @(posedge clk); #1 a_in_valid = 1'b0;
      #1;
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_lat1 got v=%b want 0", a_out_valid);
      end
      @(posedge clk); #2;
      checks++;
      if ({a_out_valid, a_out_data, a_out_tag} !== {1'b1, e[31:0], 5'd22}) begin
         errors++;
         $display("[TB] FAIL flush_after got v=%b d=%h t=%0d want v=1 d=%h t=22",
                  a_out_valid, a_out_data, a_out_tag, e[31:0]);
      end
      @(posedge clk); #1 drive_a(32'h0BADF00D, 2'd0, 2'd2, 1'b0, 5'd23); flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0; a_in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (a_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_discard[%0d] got v=%b t=%0d want 0", k, a_out_valid, a_out_tag);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random32();
      logic [64:0] q[$];
      logic [4:0]  qt[$];
      logic [31:0] d;
      logic [1:0]  off, sz;
      logic        u;
      logic [4:0]  t;
      logic [64:0] e;
      logic [4:0]  et;
      bit have = 0, fire_in, fire_out;
      int sent = 0, rx = 0, cyc = 0;
      localparam int N = 150;
      d = '0; off = '0; sz = '0; u = 1'b0; t = '0;
      while (rx < N && cyc < 3000) begin
         @(posedge clk);
         if (fire_in) begin
            q.push_back(ref_load(32, {32'd0, d}, int'(off), int'(sz), u));
            qt.push_back(t);
            have = 0; sent++;
         end
         #1;
         if (!have && sent < N && $urandom_range(0, 3) != 0) begin
            d = $urandom; off = 2'($urandom_range(0, 3)); sz = 2'($urandom_range(0, 3));
            u = 1'($urandom_range(0, 1)); t = 5'($urandom);
            have = 1;
         end
         if (have) drive_a(d, off, sz, u, t);
         else a_in_valid = 1'b0;
         a_out_ready = ($urandom_range(0, 9) < 7);
         #1;
         fire_in  = a_in_valid && a_in_ready;
         fire_out = a_out_valid && a_out_ready;
         if (fire_out) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("[TB] FAIL rnd32_extra got d=%h t=%0d want no output", a_out_data, a_out_tag);
            end else begin
               e = q.pop_front(); et = qt.pop_front();
               if ({a_out_data, a_out_mis, a_out_tag} !== {e[31:0], e[64], et}) begin
                  errors++;
                  $display("[TB] FAIL rnd32[%0d] got d=%h m=%b t=%0d want d=%h m=%b t=%0d",
                           rx, a_out_data, a_out_mis, a_out_tag, e[31:0], e[64], et);
               end
            end
            rx++;
         end
         cyc++;
      end
      @(posedge clk); #1 a_in_valid = 1'b0; a_out_ready = 1'b1;
      checks++;
      if (rx != N || q.size() != 0) begin
         errors++;
         $display("[TB] FAIL rnd32_count got recv=%0d left=%0d want %0d 0", rx, q.size(), N);
      end
   endtask

   task automatic test_xlen64();
      vec_t v[8];
      logic [64:0] e[$];
      logic [64:0] x;
      logic [63:0] rd;
      localparam logic [63:0] W64 = 64'h80000000_12345678;
      localparam int N = 40;
      v[0] = '{3'd4, 2'd2, 1'b0, 64'hFFFFFFFF80000000, 1'b0};
      v[1] = '{3'd4, 2'd2, 1'b1, 64'h0000000080000000, 1'b0};
      v[2] = '{3'd0, 2'd3, 1'b0, W64,                  1'b0};
      v[3] = '{3'd0, 2'd2, 1'b0, 64'h0000000012345678, 1'b0};
      v[4] = '{3'd6, 2'd1, 1'b0, 64'hFFFFFFFFFFFF8000, 1'b0};
      v[5] = '{3'd2, 2'd2, 1'b0, 64'h0,                1'b1};
      v[6] = '{3'd4, 2'd3, 1'b0, 64'h0,                1'b1};
      v[7] = '{3'd7, 2'd0, 1'b1, 64'h0000000000000080, 1'b0};
      b_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1 drive_b(W64, v[i].off, v[i].size, v[i].uns, 5'(i + 10));
         @(posedge clk); #1 b_in_valid = 1'b0;
         @(posedge clk); #2;
         checks++;
         if ({b_out_valid, b_out_data, b_out_mis, b_out_tag} !== {1'b1, v[i].exp, v[i].mis, 5'(i + 10)}) begin
            errors++;
            $display("[TB] FAIL dir64[%0d] got v=%b d=%h m=%b t=%0d want v=1 d=%h m=%b t=%0d",
                     i, b_out_valid, b_out_data, b_out_mis, b_out_tag, v[i].exp, v[i].mis, i + 10);
         end
      end
      @(posedge clk);
      for (int c = 0; c < N + 2; c++) begin
         #1;
         if (c < N) begin
            rd = {$urandom, $urandom};
            drive_b(rd, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'(c));
            e.push_back(ref_load(64, rd, int'(b_in_offset), int'(b_in_size), b_in_unsigned));
         end else begin
            b_in_valid = 1'b0;
         end
         #1;
         if (c >= 2) begin
            x = e.pop_front();
            checks++;
            if ({b_out_valid, b_out_data, b_out_mis, b_out_tag, b_in_ready} !== {1'b1, x[63:0], x[64], 5'(c - 2), 1'b1}) begin
               errors++;
               $display("[TB] FAIL stream64[%0d] got v=%b d=%h m=%b t=%0d rdy=%b want v=1 d=%h m=%b t=%0d rdy=1",
                        c - 2, b_out_valid, b_out_data, b_out_mis, b_out_tag, b_in_ready, x[63:0], x[64], c - 2);
            end
         end
         @(posedge clk);
      end
   endtask

   task automatic test_async_reset();
      #1 a_out_ready = 1'b0; b_out_ready = 1'b0;
      drive_a(32'h12345678, 2'd0, 2'd2, 1'b0, 5'd7);
      drive_b(64'h80000000_12345678, 3'd4, 2'd2, 1'b0, 5'd8);
      @(posedge clk); #1 a_in_valid = 1'b0; b_in_valid = 1'b0;
      @(posedge clk); #2;
      checks++;
      if (a_out_valid !== 1'b1 || b_out_valid !== 1'b1 || b_out_data !== 64'hFFFFFFFF80000000) begin
         errors++;
         $display("[TB] FAIL arst_pre got v32=%b v64=%b d64=%h want 1 1 ffffffff80000000",
                  a_out_valid, b_out_valid, b_out_data);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({a_out_valid, b_out_valid, b_out_data, a_out_data, a_in_ready, b_in_ready} !== {1'b0, 1'b0, 64'd0, 32'd0, 1'b1, 1'b1}) begin
         errors++;
         $display("[TB] FAIL arst_mid got v32=%b v64=%b d64=%h d32=%h rdy=%b%b want 0 0 0 0 11",
                  a_out_valid, b_out_valid, b_out_data, a_out_data, a_in_ready, b_in_ready);
      end
      @(posedge clk); #1 rst = 1'b0; a_out_ready = 1'b1; b_out_ready = 1'b1;
      @(posedge clk); #2;
      checks++;
      if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL arst_lost got v32=%b v64=%b want 0 0", a_out_valid, b_out_valid);
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_directed32();
      test_back_to_back();
      test_flush();
      test_random32();
      test_xlen64();
      @(posedge clk);
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
